// File: rtl/icache_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_pkg
//  Purpose  : Shared state encoding, default geometry and width helpers for
//             the instruction cache and its refill engine.
//  Revision : 1.0  initial release
// ============================================================================
package icache_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;

    // Byte-offset bits of a line address (word select plus byte lanes).
    function automatic int offb(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int idxb(input int lines);
        return $clog2(lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fill_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_if
//  Purpose  : Fetch-side lookup and backing-memory refill signals of the
//             instruction cache, seen from the cache (slave) or its peers.
//  Revision : 1.0  initial release
// ============================================================================
interface icache_fill_if;

    logic [31:0] pc_req_sy0;
    logic        inv_all;
    logic [31:0] instr_fill_sy0;
    logic        ic_miss_sy0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_val;
    logic [31:0] mem_data;
    logic [15:0] miss_cnt;

    modport master (
        output pc_req_sy0, inv_all, mem_ack, mem_val, mem_data,
        input  instr_fill_sy0, ic_miss_sy0, mem_req, mem_addr, miss_cnt
    );

    modport slave (
        input  pc_req_sy0, inv_all, mem_ack, mem_val, mem_data,
        output instr_fill_sy0, ic_miss_sy0, mem_req, mem_addr, miss_cnt
    );

endinterface
`default_nettype wire

// File: rtl/icache_fill_array.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_array
//  Purpose  : Tag, valid and data storage of the direct-mapped I-cache with a
//             combinational read port and a whole-line write port.
//  Revision : 1.0  initial release
// ============================================================================
module icache_fill_array
    import icache_fill_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    input  wire logic [idxb(LINES)-1:0]            rd_idx,
    input  wire logic [offb(WORDS)-3:0]            rd_word,
    output      logic [31-offb(WORDS)-idxb(LINES):0] rd_tag,
    output      logic                              rd_valid,
    output      logic [31:0]                       rd_data,
    input  wire logic                              wr_en,
    input  wire logic [idxb(LINES)-1:0]            wr_idx,
    input  wire logic [31-offb(WORDS)-idxb(LINES):0] wr_tag,
    input  wire logic                              wr_valid,
    input  wire logic [WORDS*32-1:0]               wr_line,
    input  wire logic                              clr_all
);

    localparam int OFFB = offb(WORDS);
    localparam int IDXB = idxb(LINES);
    localparam int TAGB = 32 - OFFB - IDXB;

    logic [TAGB-1:0]     r_tag  [LINES];
    logic [WORDS*32-1:0] r_data [LINES];
    logic [LINES-1:0]    r_valid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_line;
        end
    end

    // Clear-all outranks a concurrent line install.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (clr_all) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= wr_valid;
        end
    end

    assign rd_tag   = r_tag[rd_idx];
    assign rd_valid = r_valid[rd_idx];
    assign rd_data  = r_data[rd_idx][{rd_word, 5'd0} +: 32];

endmodule
`default_nettype wire

// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill
//  Purpose  : Direct-mapped read-only instruction cache: zero-latency hit
//             lookup plus a line-refill FSM towards backing memory.
//  Revision : 1.0  initial release
// ============================================================================
module icache_fill
    import icache_fill_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  wire logic    clk,
    input  wire logic    reset,
    icache_fill_if.slave bus
);

    localparam int OFFB = offb(WORDS);
    localparam int IDXB = idxb(LINES);
    localparam int TAGB = 32 - OFFB - IDXB;
    localparam int BCB  = OFFB - 2;
    localparam logic [BCB-1:0] c_last_beat = BCB'(WORDS - 1);

    state_t              r_state;
    logic [31:0]         r_miss_addr;
    logic [WORDS*32-1:0] r_line;
    logic [BCB-1:0]      r_beat;
    logic                r_squash;
    logic                r_mem_req;
    logic [15:0]         r_miss_cnt;

    logic [IDXB-1:0] w_idx;
    logic [BCB-1:0]  w_word;
    logic [TAGB-1:0] w_tag;
    logic [TAGB-1:0] w_rd_tag;
    logic            w_rd_valid;
    logic [31:0]     w_rd_data;
    logic            w_hit;
    logic            w_wr_en;
    logic [1:0]      w_unused_pc;

    assign w_idx       = bus.pc_req_sy0[OFFB+IDXB-1:OFFB];
    assign w_word      = bus.pc_req_sy0[OFFB-1:2];
    assign w_tag       = bus.pc_req_sy0[31:OFFB+IDXB];
    assign w_unused_pc = bus.pc_req_sy0[1:0];
    assign w_wr_en     = (r_state == ST_WRITE);

    icache_fill_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (w_idx),
        .rd_word  (w_word),
        .rd_tag   (w_rd_tag),
        .rd_valid (w_rd_valid),
        .rd_data  (w_rd_data),
        .wr_en    (w_wr_en),
        .wr_idx   (r_miss_addr[OFFB+IDXB-1:OFFB]),
        .wr_tag   (r_miss_addr[31:OFFB+IDXB]),
        .wr_valid (!r_squash),
        .wr_line  (r_line),
        .clr_all  (bus.inv_all)
    );

    // Lookups are only trusted in IDLE so a half-built line is never served.
    assign w_hit = (r_state == ST_IDLE) && w_rd_valid && (w_rd_tag == w_tag);

    assign bus.ic_miss_sy0    = !w_hit;
    assign bus.instr_fill_sy0 = w_hit ? w_rd_data : 32'd0;
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_addr       = r_miss_addr;
    assign bus.miss_cnt       = r_miss_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_miss_addr <= '0;
            r_line      <= '0;
            r_beat      <= '0;
            r_squash    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_miss_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_hit) begin
                        r_miss_addr <= {bus.pc_req_sy0[31:OFFB], {OFFB{1'b0}}};
                        if (r_miss_cnt != 16'hFFFF) begin
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        end
                        r_mem_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.inv_all) begin
                        r_squash <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.inv_all) begin
                        r_squash <= 1'b1;
                    end
                    if (bus.mem_val) begin
                        r_line[{r_beat, 5'd0} +: 32] <= bus.mem_data;
                        r_beat <= r_beat + BCB'(1);
                        if (r_beat == c_last_beat) begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    r_squash <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fill
//  Purpose  : Directed bench for icache_fill with a background memory
//             responder and a queue of expected fetch words.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_fill;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_fill_if ifc();

    icache_fill #(
        .LINES (16),
        .WORDS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int          errors    = 0;
    int          checks    = 0;
    int          ack_delay = 0;
    int          beat_cnt  = 0;
    logic [31:0] exp_q[$];

    // Backing memory image: line 0x40 holds 0xA0..0xA3.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h40) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin : responder
        logic [31:0] addr;
        ifc.mem_ack  = 1'b0;
        ifc.mem_val  = 1'b0;
        ifc.mem_data = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (ifc.mem_req === 1'b1) begin
                addr = ifc.mem_addr;
                repeat (ack_delay) begin
                    @(posedge clk); #1;
                end
                ifc.mem_ack = 1'b1;
                @(posedge clk); #1;
                ifc.mem_ack = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    ifc.mem_val  = 1'b1;
                    ifc.mem_data = mem_word(addr + 32'(4 * i));
                    @(posedge clk); #1;
                    beat_cnt++;
                end
                ifc.mem_val = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_pc(input logic [31:0] pc, input bit push);
        @(posedge clk); #1;
        ifc.pc_req_sy0 = pc;
        if (push) exp_q.push_back(mem_word(pc));
    endtask

    task automatic wait_hit(output int k);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (ifc.ic_miss_sy0 === 1'b0) return;
        end
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beats", 32'(beat_cnt), 32'(target));
    endtask

    task automatic pop_data(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
        else                   e = exp_q.pop_front();
        check({tag, "_data"}, ifc.instr_fill_sy0, e);
    endtask

    task automatic expect_hit_now(input string tag);
        @(negedge clk);
        check({tag, "_miss"}, 32'(ifc.ic_miss_sy0), 32'd0);
        pop_data(tag);
    endtask

    task automatic expect_miss_then_fill(input string tag);
        int k;
        @(negedge clk);
        check({tag, "_miss"}, 32'(ifc.ic_miss_sy0), 32'd1);
        check({tag, "_zero"}, ifc.instr_fill_sy0, 32'd0);
        wait_hit(k);
        check({tag, "_hit"}, 32'(ifc.ic_miss_sy0), 32'd0);
        pop_data(tag);
    endtask

    initial begin : stimulus
        int k;
        int bb;
        reset          = 1'b1;
        ifc.pc_req_sy0 = 32'h40;
        ifc.inv_all    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_miss", 32'(ifc.ic_miss_sy0), 32'd1);
        check("rst_req", 32'(ifc.mem_req), 32'd0);
        check("rst_addr", ifc.mem_addr, 32'd0);
        check("rst_cnt", 32'(ifc.miss_cnt), 32'd0);
        check("rst_fill", ifc.instr_fill_sy0, 32'd0);

        // Cold miss on 0x40
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(mem_word(32'h40));
        @(negedge clk);
        check("cold_pre_req", 32'(ifc.mem_req), 32'd0);
        @(negedge clk);
        check("cold_req", 32'(ifc.mem_req), 32'd1);
        check("cold_addr", ifc.mem_addr, 32'h40);
        check("cold_miss", 32'(ifc.ic_miss_sy0), 32'd1);
        check("cold_cnt", 32'(ifc.miss_cnt), 32'd1);
        wait_hit(k);
        check("cold_latency", 32'(k), 32'd6);
        pop_data("cold");
        set_pc(32'h4C, 1'b1);
        expect_hit_now("cold_w3");
        check("cold_cnt2", 32'(ifc.miss_cnt), 32'd1);

        // Conflict on index 4
        set_pc(32'h440, 1'b1);
        expect_miss_then_fill("conf_440");
        set_pc(32'h40, 1'b1);
        expect_miss_then_fill("conf_40");
        check("conf_cnt", 32'(ifc.miss_cnt), 32'd3);

        // InvAll in IDLE: effective at the following edge only
        @(posedge clk); #1;
        ifc.inv_all = 1'b1;
        @(negedge clk);
        check("inv_idle_before", 32'(ifc.ic_miss_sy0), 32'd0);
        @(posedge clk); #1;
        ifc.inv_all = 1'b0;
        exp_q.push_back(mem_word(32'h40));
        @(negedge clk);
        check("inv_idle_after", 32'(ifc.ic_miss_sy0), 32'd1);
        wait_hit(k);
        pop_data("inv_idle_refill");
        check("inv_idle_cnt", 32'(ifc.miss_cnt), 32'd4);

        // InvAll during FILL squashes the install
        bb = beat_cnt;
        set_pc(32'h100, 1'b1);
        wait_beats(bb + 1);
        @(posedge clk); #1;
        ifc.inv_all = 1'b1;
        @(posedge clk); #1;
        ifc.inv_all = 1'b0;
        wait_beats(bb + 4);
        @(negedge clk);
        check("squash_miss", 32'(ifc.ic_miss_sy0), 32'd1);
        wait_hit(k);
        pop_data("squash_refill");
        check("squash_cnt", 32'(ifc.miss_cnt), 32'd6);

        // Redirect during FILL: 0x40 still installed, 0x80 refilled after
        bb = beat_cnt;
        set_pc(32'h40, 1'b0);
        wait_beats(bb + 1);
        set_pc(32'h80, 1'b1);
        wait_hit(k);
        pop_data("redirect_80");
        check("redirect_cnt", 32'(ifc.miss_cnt), 32'd8);
        set_pc(32'h40, 1'b1);
        expect_hit_now("redirect_40");

        // Stalled memory ack
        ack_delay = 5;
        set_pc(32'h200, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_req", 32'(ifc.mem_req), 32'd1);
            check("stall_addr", ifc.mem_addr, 32'h200);
            check("stall_miss", 32'(ifc.ic_miss_sy0), 32'd1);
            check("stall_fill", ifc.instr_fill_sy0, 32'd0);
        end
        wait_hit(k);
        pop_data("stall");
        check("stall_cnt", 32'(ifc.miss_cnt), 32'd9);
        ack_delay = 0;

        // Reset after two beats of a refill
        bb = beat_cnt;
        set_pc(32'h300, 1'b0);
        wait_beats(bb + 2);
        ifc.pc_req_sy0 = 32'h80;
        reset = 1'b1;
        #1;
        check("rmid_req", 32'(ifc.mem_req), 32'd0);
        check("rmid_cnt", 32'(ifc.miss_cnt), 32'd0);
        check("rmid_addr", ifc.mem_addr, 32'd0);
        check("rmid_miss", 32'(ifc.ic_miss_sy0), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(mem_word(32'h80));
        @(negedge clk);
        check("rmid_relookup", 32'(ifc.ic_miss_sy0), 32'd1);
        wait_hit(k);
        pop_data("rmid_refill");
        check("rmid_cnt2", 32'(ifc.miss_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
